// File: rtl/clock_counter.sv
// clock_counter: mm:ss BCD clock driven by a 0..CLK_HZ-1 prescaler.
// A terminal prescaler edge advances the seconds and pulses tick_1hz. A
// 59:59 -> 00:00 wrap caused by a tick also pulses rollover.
// Optional build macro SET_BUTTONS_EN: edge-detects inc_min to advance the
// minutes. An advance that lands on a seconds carry is held pending for one
// edge. Without the macro, inc_min is accepted but ignored.
module clock_counter #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       clear,
    input  logic       inc_min,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic [3:0] thousands,
    output logic       tick_1hz,
    output logic       rollover
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    sec_ones_q, sec_ones_d;
    logic [3:0]    sec_tens_q, sec_tens_d;
    logic [3:0]    min_ones_q, min_ones_d;
    logic [3:0]    min_tens_q, min_tens_d;
    logic          tick_q, tick_d;
    logic          roll_q, roll_d;

    logic          terminal;
    logic          sec_carry;
    logic          min_req;

    // terminal edge of the prescaler and the seconds-to-minutes carry it causes
    always_comb begin
        terminal  = enable && (presc_q == PRESC_MAX);
        sec_carry = terminal && (sec_ones_q >= 4'd9) && (sec_tens_q >= 4'd5);
    end

`ifdef SET_BUTTONS_EN
    logic inc_q;
    logic pend_q, pend_d;

    // A new press, or one deferred from a carry edge, requests a minute advance.
    // If it collides with a carry, it is deferred to the following edge.
    always_comb begin
        min_req = (inc_min && !inc_q) || pend_q;
        pend_d  = clear ? 1'b0 : (min_req && sec_carry);
    end

    // The inc_min history keeps tracking during clear, so a level held
    // across clear cannot produce a late advance.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            inc_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            inc_q  <= inc_min;
            pend_q <= pend_d;
        end
    end
`else
    logic unused_inc_min;

    // inc_min has no effect in this build
    always_comb begin
        unused_inc_min = inc_min;
        min_req        = 1'b0;
    end
`endif

    // next time, prescaler and pulses; clear overrides tick and minute advance
    always_comb begin
        presc_d    = presc_q;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        tick_d     = 1'b0;
        roll_d     = 1'b0;

        if (clear) begin
            presc_d    = '0;
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            min_ones_d = 4'd0;
            min_tens_d = 4'd0;
        end else begin
            if (enable) begin
                presc_d = terminal ? '0 : presc_q + 1'b1;
            end
            tick_d = terminal;
            roll_d = sec_carry && (min_tens_q >= 4'd5) && (min_ones_q >= 4'd9);

            if (terminal) begin
                if (sec_ones_q >= 4'd9) begin
                    sec_ones_d = 4'd0;
                    sec_tens_d = (sec_tens_q >= 4'd5) ? 4'd0 : sec_tens_q + 4'd1;
                end else begin
                    sec_ones_d = sec_ones_q + 4'd1;
                end
            end

            if (sec_carry || min_req) begin
                if (min_ones_q >= 4'd9) begin
                    min_ones_d = 4'd0;
                    min_tens_d = (min_tens_q >= 4'd5) ? 4'd0 : min_tens_q + 4'd1;
                end else begin
                    min_ones_d = min_ones_q + 4'd1;
                end
            end
        end
    end

    // state and registered outputs
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            presc_q    <= '0;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            tick_q     <= 1'b0;
            roll_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            tick_q     <= tick_d;
            roll_q     <= roll_d;
        end
    end

    assign ones      = sec_ones_q;
    assign tens      = sec_tens_q;
    assign hundreds  = min_ones_q;
    assign thousands = min_tens_q;
    assign tick_1hz  = tick_q;
    assign rollover  = roll_q;

endmodule

// File: tb/tb_clock_counter.sv
// Bench for clock_counter at CLK_HZ=10. The reference model keeps the time as
// total seconds (0..3599), along with a prescaler count and a pending-advance
// flag. Outputs are compared against it after every clock edge.
module tb_clock_counter;

    localparam int CLK_HZ = 10;
`ifdef SET_BUTTONS_EN
    localparam bit BUTTONS = 1'b1;
`else
    localparam bit BUTTONS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic       inc_min = 1'b0;
    logic [3:0] ones, tens, hundreds, thousands;
    logic       tick_1hz, rollover;
    logic [15:0] digits;

    int tests = 0;
    int fails = 0;

    int m_t;
    int m_presc;
    bit m_pend, m_prev, m_tick, m_roll;

    clock_counter #(.CLK_HZ(CLK_HZ)) dut (
        .clk_100MHz(clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .clear     (clear),
        .inc_min   (inc_min),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands),
        .tick_1hz  (tick_1hz),
        .rollover  (rollover)
    );

    assign digits = {thousands, hundreds, tens, ones};

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before the end of the sequence");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] bcd(input int t);
        return {4'(t / 600), 4'((t / 60) % 10), 4'((t % 60) / 10), 4'(t % 10)};
    endfunction

    function automatic int add_minute(input int t);
        return (((t / 60) + 1) % 60) * 60 + (t % 60);
    endfunction

    function automatic void model_reset();
        m_t = 0; m_presc = 0; m_pend = 0; m_prev = 0; m_tick = 0; m_roll = 0;
    endfunction

    function automatic void model_edge();
        bit term, carry, adv;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (clear) begin
            m_t = 0; m_presc = 0; m_pend = 0; m_tick = 0; m_roll = 0;
            m_prev = inc_min;
            return;
        end
        term = enable && (m_presc == CLK_HZ - 1);
        if (enable) m_presc = term ? 0 : m_presc + 1;
        m_tick = term;
        m_roll = term && (m_t == 3599);
        carry  = term && (m_t % 60 == 59);
        adv    = BUTTONS && ((inc_min && !m_prev) || m_pend);
        if (term) m_t = (m_t + 1) % 3600;
        if (adv && carry) m_pend = 1;
        else if (adv) begin
            m_t    = add_minute(m_t);
            m_pend = 0;
        end
        m_prev = inc_min;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check(tag, {14'd0, digits, tick_1hz, rollover}, {14'd0, bcd(m_t), m_tick, m_roll});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            check_model("cycle");
        end
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_model("async_reset");
        step(2);
        reset_n = 1'b1;
    endtask

    // Leaves the time at target with the next enabled edge being terminal.
    task automatic seek(input int target);
        int guard;
        guard = 0;
        enable = 1'b1;
        inc_min = 1'b0;
        while (!((m_t % 60) == (target % 60) && m_presc == CLK_HZ - 1) && guard < 2000) begin
            step(1);
            guard++;
        end
        while (m_t != target && guard < 50000) begin
`ifdef SET_BUTTONS_EN
            enable = 1'b0;
            inc_min = 1'b1;
            step(1);
            inc_min = 1'b0;
            step(1);
            enable = 1'b1;
            guard += 2;
`else
            step(CLK_HZ * 60);
            guard += CLK_HZ * 60;
`endif
        end
        check("seek", {16'd0, digits}, {16'd0, bcd(target)});
    endtask

    initial begin
        // reset state
        model_reset();
        #3;
        check_model("reset_state");
        check("reset_digits", {16'd0, digits}, 32'h0000);
        step(2);

        // first second after release
        reset_n = 1'b1;
        enable = 1'b1;
        step(9);
        check("pre_tick", {31'd0, tick_1hz}, 32'd0);
        step(1);
        check("first_sec_digits", {16'd0, digits}, 32'h0001);
        check("first_sec_tick", {31'd0, tick_1hz}, 32'd1);
        check("first_sec_roll", {31'd0, rollover}, 32'd0);
        step(1);
        check("tick_one_cycle", {31'd0, tick_1hz}, 32'd0);

        // pause holds the prescaler
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(5);
        enable = 1'b0;
        step(50);
        check("pause_digits", {16'd0, digits}, 32'h0000);
        enable = 1'b1;
        step(4);
        check("resume_no_tick", {31'd0, tick_1hz}, 32'd0);
        step(1);
        check("resume_tick", {31'd0, tick_1hz}, 32'd1);

        // reset mid-count drops the partial second
        step(3);
        do_reset();
        step(9);
        check("post_reset_no_tick", {31'd0, tick_1hz}, 32'd0);
        step(1);
        check("post_reset_tick", {31'd0, tick_1hz}, 32'd1);

        // clear on the terminal edge at 07:30
        seek(450);
        clear = 1'b1;
        step(1);
        check("clear_digits", {16'd0, digits}, 32'h0000);
        check("clear_no_tick", {31'd0, tick_1hz}, 32'd0);
        clear = 1'b0;
        step(9);
        check("after_clear_no_tick", {31'd0, tick_1hz}, 32'd0);
        step(1);
        check("after_clear_tick", {31'd0, tick_1hz}, 32'd1);
        check("after_clear_digits", {16'd0, digits}, 32'h0001);

        // 59:58 -> 59:59 -> 00:00 with rollover
        seek(3598);
        step(1);
        check("to_5959", {16'd0, digits}, 32'h5959);
        check("to_5959_roll", {31'd0, rollover}, 32'd0);
        step(10);
        check("wrap_digits", {16'd0, digits}, 32'h0000);
        check("wrap_tick", {31'd0, tick_1hz}, 32'd1);
        check("wrap_roll", {31'd0, rollover}, 32'd1);
        step(1);
        check("roll_one_cycle", {31'd0, rollover}, 32'd0);

        // inc_min toggled 20 times at 03:03 while paused
        seek(183);
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            inc_min = 1'b1;
            step(1);
            check("inc_no_tick", {31'd0, tick_1hz}, 32'd0);
            inc_min = 1'b0;
            step(1);
        end
`ifdef SET_BUTTONS_EN
        check("inc_toggle_time", {16'd0, digits}, 32'h2303);
`else
        check("inc_ignored_time", {16'd0, digits}, 32'h0303);
`endif

`ifdef SET_BUTTONS_EN
        // press landing on the carry edge at 12:59
        seek(779);
        inc_min = 1'b1;
        step(1);
        check("carry_first", {16'd0, digits}, 32'h1300);
        check("carry_tick", {31'd0, tick_1hz}, 32'd1);
        step(1);
        check("pending_applied", {16'd0, digits}, 32'h1400);
        step(20);
        check("held_no_advance", {24'd0, digits[15:8]}, 32'h14);
        inc_min = 1'b0;
        step(1);
`endif

        // inc_min held high through reset release
        inc_min = 1'b1;
        enable = 1'b0;
        do_reset();
        step(1);
`ifdef SET_BUTTONS_EN
        check("held_through_reset", {16'd0, digits}, 32'h0100);
`else
        check("held_through_reset", {16'd0, digits}, 32'h0000);
`endif
        step(3);
        inc_min = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom % 8) != 0;
            clear  = ($urandom % 64) == 0;
            if ($urandom % 4 == 0) inc_min = ~inc_min;
            if ($urandom % 400 == 0) do_reset();
            step(1);
        end
        clear = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clock_counter.md
CLOCK_COUNTER -- requirements
Module: clock_counter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000: input clock cycles per one-second tick; legal range 2..2^27.
REQ-002 SHALL have port clk_100MHz  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port enable  input  1  count run (1) / pause (0), synchronous level.
REQ-005 SHALL have port clear  input  1  synchronous zero of time and prescaler.
REQ-006 SHALL have port inc_min  input  1  minute-advance request; synchronous, debounced level.
REQ-007 SHALL have port ones  output  4  seconds units, BCD 0..9.
REQ-008 SHALL have port tens  output  4  seconds tens, BCD 0..5.
REQ-009 SHALL have port hundreds  output  4  minutes units, BCD 0..9.
REQ-010 SHALL have port thousands  output  4  minutes tens, BCD 0..5.
REQ-011 SHALL have port tick_1hz  output  1  one-cycle pulse per seconds increment.
REQ-012 SHALL have port rollover  output  1  one-cycle pulse on the 59:59 -> 00:00 wrap.

Function
REQ-013 Prescaler SHALL count 0..CLK_HZ-1 while enable=1 and hold its value while enable=0.
REQ-014 The terminal condition is prescaler == CLK_HZ-1 with enable=1; on that edge the prescaler SHALL wrap to 0 and the seconds SHALL increment by one.
REQ-015 All outputs SHALL be registered; the new digit values and tick_1hz=1 SHALL appear together in the cycle after the terminal edge.
REQ-016 Seconds SHALL wrap 59 -> 00 and carry +1 into the minutes in the same edge; minutes SHALL wrap 59 -> 00.
REQ-017 On a 59:59 -> 00:00 transition caused by a tick, rollover SHALL be 1 for exactly the same cycle as tick_1hz.
REQ-018 Digit outputs SHALL never leave their stated BCD ranges under any input sequence.
REQ-019 inc_min SHALL be edge-detected against a registered copy of itself; each 0 -> 1 transition SHALL create exactly one minute advance, and a held level SHALL NOT create further advances.
REQ-020 A minute advance SHALL add one minute (59 -> 00 wrap), SHALL leave the seconds unchanged, SHALL NOT assert tick_1hz or rollover, and SHALL work with enable=0.
REQ-021 If a minute advance coincides with a seconds carry into the minutes, the carry SHALL apply first and the advance SHALL be held pending and applied on the next edge.
REQ-022 clear=1 SHALL, on that edge, zero all digits, the prescaler, the pending advance and both pulses; clear SHALL override the tick and inc_min.
REQ-023 clear held high SHALL keep the time at 00:00; counting SHALL resume from prescaler 0 on the first edge after clear falls.

Reset
REQ-024 On reset_n=0, asynchronously: ones, tens, hundreds and thousands = 0; tick_1hz = 0; rollover = 0; prescaler = 0; pending advance = 0; inc_min edge register = 0.
REQ-025 Reset asserted mid-count SHALL discard the partial second; after release, the first tick SHALL come exactly CLK_HZ enabled cycles later.
REQ-026 inc_min held high through reset release SHALL count as one 0 -> 1 edge on the first clock after release.

Configuration
REQ-027 With macro SET_BUTTONS_EN defined, the inc_min edge detection and the pending advance (REQ-019..REQ-021, REQ-026) SHALL be built in.
REQ-028 Without SET_BUTTONS_EN, the inc_min port SHALL still exist but SHALL be ignored; no edge or pending logic SHALL be built, and the minutes SHALL change only by seconds carry.

Verification (CLK_HZ=10 unless stated)
REQ-029 Bench: reset_n low, then release with enable=1 for 10 cycles -> digits read 00:01; tick_1hz high exactly one cycle; rollover stays 0.
REQ-030 Bench: preload 59:58 via inc_min and ticks, run 2 ticks -> 59:59, then 00:00; rollover and tick_1hz both high in the wrap cycle.
REQ-031 Bench: enable=0 after 5 cycles, hold for 50 cycles, then enable=1 -> next tick after exactly 5 more cycles.
REQ-032 Bench: at 12:59, a 0 -> 1 edge on inc_min in the carry edge -> 13:00, then 14:00 one cycle later; holding inc_min high gives no further advance.
REQ-033 Bench: clear pulsed on the terminal edge at 07:30 -> 00:00, no tick_1hz; the next tick comes 10 cycles after clear falls.
REQ-034 Bench: build without SET_BUTTONS_EN, toggle inc_min 20 times at 03:03 with enable=0 -> time stays 03:03.
